// File: rtl/util_arb_pkg.sv
// rtl/util_arb_pkg.sv - shared types and round-robin helper for util_arb4
package util_arb_pkg;

   localparam int ARB_N     = 4;
   localparam int ARB_SEL_W = 2;

   typedef enum logic {IDLE, OWN} arb_state_t;

   typedef logic [ARB_N-1:0]     arb_vec_t;
   typedef logic [ARB_SEL_W-1:0] arb_sel_t;

   typedef struct packed {
      logic     found;
      arb_sel_t idx;
   } arb_pick_t;

   // Scan ptr+1 .. ptr+4 (mod 4); the first set bit wins.
   function automatic arb_pick_t rr_next(input arb_vec_t vec, input arb_sel_t ptr);
      arb_pick_t res;
      arb_sel_t  k;
      res = '0;
      for (int i = 1; i <= ARB_N; i++) begin
         k = ptr + ARB_SEL_W'(i);
         if (!res.found && vec[k]) begin
            res.found = 1'b1;
            res.idx   = k;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/util_arb_pick4.sv
// rtl/util_arb_pick4.sv - combinational round-robin priority encoder
import util_arb_pkg::*;

module util_arb_pick4 (
   input  logic [ARB_N-1:0]     req,
   input  logic [ARB_N-1:0]     mask,
   input  logic [ARB_SEL_W-1:0] ptr,
   output logic [ARB_SEL_W-1:0] idx,
   output logic                 found
);

   arb_pick_t pick;

   // Pick the next eligible requester after the pointer.
   always_comb begin
      pick = rr_next(req & mask, ptr);
   end

   assign idx   = pick.idx;
   assign found = pick.found;

endmodule

// File: rtl/util_arb4.sv
// rtl/util_arb4.sv - four-requester round-robin bus arbiter with bounded bursts (option: ARB_PRIO0_EN)
import util_arb_pkg::*;

module util_arb4 #(
   parameter int MAX_BURST = 4,
   parameter int RESET_PTR = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ARB_N-1:0]     req,
   input  logic [ARB_N-1:0]     lock,
   input  logic                 ready,
   output logic [ARB_N-1:0]     grant,
   output logic [ARB_SEL_W-1:0] sel,
   output logic                 busy,
   output logic                 beat
);

   localparam logic [3:0]     MAX_B   = 4'(MAX_BURST);
   localparam logic [1:0]     RST_PTR = 2'(RESET_PTR);
   localparam logic [ARB_N-1:0] ONE   = {{(ARB_N-1){1'b0}}, 1'b1};

   arb_state_t       state_q, state_d;
   arb_vec_t         grant_q, grant_d;
   arb_sel_t         sel_q,   sel_d;
   arb_sel_t         ptr_q,   ptr_d;
   logic [3:0]       cnt_q,   cnt_d;

   arb_vec_t         owner_oh;
   arb_vec_t         pick_mask;
   arb_sel_t         rr_idx;
   logic             rr_found;
   arb_sel_t         win_idx;
   logic             win_found;
   logic             win_prio;
   logic             prio_cut;
   logic [3:0]       cnt_inc;
   logic             others;
   logic             rel;

   assign owner_oh  = ONE << sel_q;
   // While owning, the current owner is excluded from the re-arbitration pick.
   assign pick_mask = (state_q == OWN) ? ~owner_oh : '1;

   util_arb_pick4 u_pick (
      .req   (req),
      .mask  (pick_mask),
      .ptr   (ptr_q),
      .idx   (rr_idx),
      .found (rr_found)
   );

`ifdef ARB_PRIO0_EN
   assign win_prio  = req[0] & pick_mask[0];
   assign win_found = win_prio | rr_found;
   assign win_idx   = win_prio ? '0 : rr_idx;
   assign prio_cut  = (state_q == OWN) && (sel_q != '0) && req[0] && !lock[sel_q];
`else
   assign win_prio  = 1'b0;
   assign win_found = rr_found;
   assign win_idx   = rr_idx;
   assign prio_cut  = 1'b0;
`endif

   assign busy    = |grant_q;
   assign beat    = busy & ready & req[sel_q];
   assign grant   = grant_q;
   assign sel     = sel_q;

   assign cnt_inc = (beat && (cnt_q < MAX_B)) ? cnt_q + 4'd1 : cnt_q;
   assign others  = |(req & ~owner_oh);
   assign rel     = !req[sel_q]
                  || ((cnt_inc >= MAX_B) && !lock[sel_q] && others)
                  || (prio_cut && beat);

   // Next-state: grant on any pick in IDLE, hand over or go idle on release in OWN.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = OWN;
               grant_d = ONE << win_idx;
               sel_d   = win_idx;
               cnt_d   = '0;
               if (!win_prio) ptr_d = win_idx;
            end
         end
         OWN: begin
            if (rel) begin
               cnt_d = '0;
               if (win_found) begin
                  grant_d = ONE << win_idx;
                  sel_d   = win_idx;
                  if (!win_prio) ptr_d = win_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State register; reset clears outputs immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= RST_PTR;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_util_arb4.sv
// tb/tb_util_arb4.sv - directed vector bench for util_arb4
module tb_util_arb4;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic [3:0] lock;
   logic       ready;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       beat;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic [3:0] lock;
      logic       ready;
      logic       e_beat;
      logic [3:0] e_grant;
      logic [1:0] e_sel;
      logic       e_busy;
   } vec_t;

   vec_t tbl[$];

   util_arb4 #(.MAX_BURST(4), .RESET_PTR(3)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .lock  (lock),
      .ready (ready),
      .grant (grant),
      .sel   (sel),
      .busy  (busy),
      .beat  (beat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input bit rst, input logic [3:0] rq, input logic [3:0] lk,
                               input logic rd, input logic eb, input logic [3:0] eg,
                               input logic [1:0] es, input logic ebz);
      vec_t v;
      v.rst = rst; v.req = rq; v.lock = lk; v.ready = rd;
      v.e_beat = eb; v.e_grant = eg; v.e_sel = es; v.e_busy = ebz;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [3:0] one;
      int         o;
      int         no;

      one   = 4'b0001;
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      ready = 1'b0;
      #1;
      chk("reset grant", grant, 4'b0000);
      chk("reset sel", {2'b00, sel}, 4'h0);
      chk("reset busy", {3'b000, busy}, 4'h0);
      chk("reset beat", {3'b000, beat}, 4'h0);

      // Single requester: grant after one cycle, drop releases to idle.
      add(1, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1);
      add(0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

`ifndef ARB_PRIO0_EN
      // All four requesting, ready always high: 4 beats each, no gap.
      add(1, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         o  = (k / 4) % 4;
         no = (k % 4 == 3) ? (o + 1) % 4 : o;
         add(0, 4'b1111, 4'b0000, 1'b1, 1'b1, one << no, 2'(no), 1'b1);
      end
`endif

      // Owner 2 alone for 20 beats, then requester 1 joins.
      add(1, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1);
      for (int k = 0; k < 20; k++)
         add(0, 4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
      add(0, 4'b0110, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
      add(0, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);

      // Owner 1 locked past the burst limit while requester 3 waits.
      add(1, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1);
      for (int k = 0; k < 9; k++)
         add(0, 4'b1010, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
      add(0, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1);

      // Owner drops while another requests: handover with no bubble, no beat.
      add(1, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1);
      add(0, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1);

      // Owner 2 bursting when requester 0 rises.
      add(1, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1);
      add(0, 4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
      add(0, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1);
`ifdef ARB_PRIO0_EN
      add(0, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
`else
      add(0, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
      add(0, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
      add(0, 4'b0101, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
`endif

      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            @(negedge clock);
            reset = 1'b1;
            req   = '0;
            lock  = '0;
            ready = 1'b0;
            @(negedge clock);
            reset = 1'b0;
         end else begin
            @(negedge clock);
         end
         req   = tbl[i].req;
         lock  = tbl[i].lock;
         ready = tbl[i].ready;
         #1;
         chk($sformatf("v%0d beat", i), {3'b000, beat}, {3'b000, tbl[i].e_beat});
         @(posedge clock);
         #1;
         chk($sformatf("v%0d grant", i), grant, tbl[i].e_grant);
         chk($sformatf("v%0d sel", i), {2'b00, sel}, {2'b00, tbl[i].e_sel});
         chk($sformatf("v%0d busy", i), {3'b000, busy}, {3'b000, tbl[i].e_busy});
      end

      // Asynchronous reset in the middle of owner 3's burst.
      @(negedge clock);
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      ready = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      req   = 4'b1000;
      @(posedge clock);
      #1;
      chk("ar grant", grant, 4'b1000);
      chk("ar sel", {2'b00, sel}, 4'h3);
      @(negedge clock);
      ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("ar mid grant", grant, 4'b0000);
      chk("ar mid sel", {2'b00, sel}, 4'h0);
      chk("ar mid busy", {3'b000, busy}, 4'h0);
      chk("ar mid beat", {3'b000, beat}, 4'h0);
      @(negedge clock);
      reset = 1'b0;
      ready = 1'b0;
      @(posedge clock);
      #1;
      chk("ar regrant", grant, 4'b1000);
      chk("ar resel", {2'b00, sel}, 4'h3);
      chk("ar rebusy", {3'b000, busy}, 4'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
